// File: rtl/dual_slope_counter_if.sv
// dual_slope_counter_if: controller <-> counting/sensing end of the dual-slope ADC.
interface dual_slope_counter_if #(parameter int DIGITS = 3) ();
  logic rst_s, enb_0, cmp_in, Vint_z, enb_3, overrange, valid;
  logic [4*DIGITS-1:0] count, result;
  modport master (output rst_s, enb_0, cmp_in, input Vint_z, enb_3, count, result, overrange, valid);
  modport slave (input rst_s, enb_0, cmp_in, output Vint_z, enb_3, count, result, overrange, valid);
endinterface

// File: rtl/dual_slope_counter.sv
// dual_slope_counter: BCD cycle counter, wrap/overrange tracker, result latch and comparator synchroniser.
module dual_slope_counter #(
  parameter int DIGITS = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  dual_slope_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;
  logic [W-1:0] count, cnt_nxt, result;
  logic [DIGITS:0] carry;
  logic [1:0] wraps;
  logic [SYNC_STAGES-1:0] sync;
  logic ovr, enb_0_d, enb_3, overrange, valid, fall, wrap;
  always_comb begin
    cnt_nxt = count;
    carry = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      carry[i+1] = carry[i] && count[4*i+:4] == 4'd9;
      cnt_nxt[4*i+:4] = !carry[i] ? count[4*i+:4] : carry[i+1] ? 4'd0 : count[4*i+:4] + 4'd1;
    end
  end
  assign wrap = carry[DIGITS];
  assign fall = enb_0_d && !bus.enb_0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wraps <= '0;
      ovr <= 1'b0;
      enb_0_d <= 1'b0;
      sync <= '0;
      enb_3 <= 1'b0;
      result <= '0;
      overrange <= 1'b0;
      valid <= 1'b0;
    end else begin
      enb_0_d <= bus.enb_0;
      sync <= {sync[SYNC_STAGES-2:0], bus.cmp_in};
      valid <= fall;
      // latch sees the pre-clear count/ovr even when rst_s lands on the same edge
      if (fall) begin
        result <= count;
        overrange <= ovr;
      end
      enb_3 <= !bus.rst_s && bus.enb_0 && wrap && wraps == 2'd0;
      if (bus.rst_s) begin
        count <= '0;
        wraps <= '0;
        ovr <= 1'b0;
      end else if (bus.enb_0) begin
        count <= cnt_nxt;
        if (wrap && wraps != 2'd2) wraps <= wraps + 2'd1;
        if (wrap && wraps == 2'd1) ovr <= 1'b1;
      end
    end
  end
  assign bus.count = count;
  assign bus.result = result;
  assign bus.overrange = overrange;
  assign bus.valid = valid;
  assign bus.enb_3 = enb_3;
  assign bus.Vint_z = sync[SYNC_STAGES-1];
endmodule

// File: tb/tb_dual_slope_counter.sv
// tb_dual_slope_counter: scoreboard bench for the dual-slope counter (DIGITS=3, SYNC_STAGES=2).
module tb_dual_slope_counter;
  localparam int D = 3;
  localparam int W = 4 * D;
  logic clk, rst;
  int checks = 0, errors = 0, vcnt = 0, e3_cnt = 0;
  logic [W:0] sb_q[$];
  dual_slope_counter_if #(.DIGITS(D)) bus ();
  dual_slope_counter #(.DIGITS(D), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear();
    bus.rst_s = 1'b1;
    tick();
    bus.rst_s = 1'b0;
  endtask
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst && bus.enb_3) e3_cnt++;
    if (!rst && bus.valid) begin
      vcnt++;
      if (sb_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        check("result", 32'(bus.result), 32'(e[W-1:0]));
        check("overrange", 32'(bus.overrange), 32'(e[W]));
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.rst_s = 1'b0;
    bus.enb_0 = 1'b0;
    bus.cmp_in = 1'b1;
    tick(2);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_vint", 32'(bus.Vint_z), 32'h0);
    rst = 1'b0;
    tick(3);
    check("vint_high", 32'(bus.Vint_z), 32'h1);
    clear();
    bus.enb_0 = 1'b1;
    tick(347);
    check("count_347", 32'(bus.count), 32'h347);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(bus.count), 32'h0);
    check("arst_vint", 32'(bus.Vint_z), 32'h0);
    check("arst_outs", 32'({bus.enb_3, bus.valid, bus.overrange, bus.result}), 32'h0);
    bus.enb_0 = 1'b0;
    bus.cmp_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("arst_no_valid", 32'(vcnt), 32'd0);
    // normal conversion
    clear();
    e3_cnt = 0;
    bus.enb_0 = 1'b1;
    tick(999);
    check("enb3_early", 32'(bus.enb_3), 32'h0);
    tick();
    check("enb3_pulse", 32'(bus.enb_3), 32'h1);
    check("wrap_count", 32'(bus.count), 32'h000);
    tick();
    check("enb3_width", 32'(bus.enb_3), 32'h0);
    tick(411);
    check("count_412", 32'(bus.count), 32'h412);
    sb_q.push_back({1'b0, 12'h412});
    bus.enb_0 = 1'b0;
    tick();
    check("valid_hi", 32'(bus.valid), 32'h1);
    check("count_hold", 32'(bus.count), 32'h412);
    tick();
    check("valid_lo", 32'(bus.valid), 32'h0);
    check("single_enb3", 32'(e3_cnt), 32'd1);
    // overrange conversion, back-to-back clear
    clear();
    check("result_persist", 32'(bus.result), 32'h412);
    e3_cnt = 0;
    bus.enb_0 = 1'b1;
    tick(2003);
    check("count_ovr", 32'(bus.count), 32'h003);
    sb_q.push_back({1'b1, 12'h003});
    bus.enb_0 = 1'b0;
    tick(2);
    check("ovr_enb3_once", 32'(e3_cnt), 32'd1);
    // clear priority
    clear();
    bus.enb_0 = 1'b1;
    tick(5);
    check("count_5", 32'(bus.count), 32'h005);
    bus.rst_s = 1'b1;
    tick();
    check("clr_beats_enb", 32'(bus.count), 32'h000);
    bus.rst_s = 1'b0;
    tick(7);
    sb_q.push_back({1'b0, 12'h007});
    bus.rst_s = 1'b1;
    bus.enb_0 = 1'b0;
    tick();
    bus.rst_s = 1'b0;
    check("clr_fall_count", 32'(bus.count), 32'h000);
    check("clr_fall_valid", 32'(bus.valid), 32'h1);
    tick(2);
    // synchroniser with asynchronous phase offsets
    for (int i = 0; i < 4; i++) begin
      logic lvl;
      lvl = (i % 2 == 0);
      @(posedge clk);
      #(1 + 2 * i);
      bus.cmp_in = lvl;
      tick();
      check("sync_old", 32'(bus.Vint_z), 32'(!lvl));
      tick();
      check("sync_new", 32'(bus.Vint_z), 32'(lvl));
      tick(3);
      check("sync_stable", 32'(bus.Vint_z), 32'(lvl));
    end
    check("valid_total", 32'(vcnt), 32'd3);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
